fb_write_arbiter: RTL and testbench

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

---
 rtl/fb_write_arbiter.sv | 138 +++++++++++++
 tb/tb_fb_write_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// Two-requester framebuffer write arbiter with locked bursts and a registered RAM write port.
// Define FB_ARB_ROUND_ROBIN_EN to break IDLE ties by round robin; otherwise requester 0 wins ties.
module fb_write_arbiter #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 64
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req1_valid,
  input  logic              req0_lock,
  input  logic              req1_lock,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_out,
  output logic              ram_write_enable,
  output logic              ram_clk_enable,
  output logic              grant_id,
  output logic              busy,
  output logic [1:0]        o_dbg_state
);

  // Handshake: a beat transfers in any cycle where reqx_valid and reqx_ready are both high;
  // valid must not depend on ready, ready may depend on valid (only in IDLE).

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  state_t            r_state;
  logic [7:0]        r_burst_cnt;
  logic              r_last_grant;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  logic              w_sel;
  logic              w_acc0;
  logic              w_acc1;
  logic [7:0]        w_cnt_inc;

  always_comb begin
    w_sel = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef FB_ARB_ROUND_ROBIN_EN
      w_sel = ~r_last_grant;
`else
      w_sel = 1'b0;
`endif
    end else if (req1_valid) begin
      w_sel = 1'b1;
    end
  end

  // Readies are forced low during reset so no beat is taken in that cycle.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset) begin
      case (r_state)
        IDLE: begin
          req0_ready = req0_valid && !w_sel;
          req1_ready = req1_valid && w_sel;
        end
        OWN0:    req0_ready = 1'b1;
        OWN1:    req1_ready = 1'b1;
        default: ;
      endcase
    end
  end

  assign w_acc0    = req0_valid && req0_ready;
  assign w_acc1    = req1_valid && req1_ready;
  assign w_cnt_inc = r_burst_cnt + 8'd1;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state      <= IDLE;
      r_burst_cnt  <= 8'd0;
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
    end else begin
      r_we <= w_acc0 || w_acc1;
      if (w_acc0) begin
        r_addr       <= req0_addr;
        r_data       <= req0_data;
        r_last_grant <= 1'b0;
      end else if (w_acc1) begin
        r_addr       <= req1_addr;
        r_data       <= req1_data;
        r_last_grant <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_acc0 && req0_lock) begin
            r_state     <= OWN0;
            r_burst_cnt <= 8'd1;
          end else if (w_acc1 && req1_lock) begin
            r_state     <= OWN1;
            r_burst_cnt <= 8'd1;
          end
        end
        OWN0: begin
          if (w_acc0) r_burst_cnt <= w_cnt_inc;
          // Dropping lock releases ownership even if this cycle's beat is still written.
          if (!req0_lock || (w_acc0 && (w_cnt_inc == MAX_B))) r_state <= IDLE;
        end
        OWN1: begin
          if (w_acc1) r_burst_cnt <= w_cnt_inc;
          if (!req1_lock || (w_acc1 && (w_cnt_inc == MAX_B))) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ram_address      = r_addr;
  assign ram_data_out     = r_data;
  assign ram_write_enable = r_we;
  assign ram_clk_enable   = r_we;
  assign grant_id         = r_last_grant;
  assign busy             = (r_state != IDLE) || r_we;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter; tie-break expectations follow FB_ARB_ROUND_ROBIN_EN.
// Instance dut_a uses the default burst limit, dut_b a limit of 4 (shared stimulus).
module tb_fb_write_arbiter;

  localparam int AW = 11;
  localparam int DW = 16;

`ifdef FB_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid, req0_lock, req1_lock;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;

  logic          a_rdy0, a_rdy1, a_we, a_ce, a_gnt, a_busy;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic [1:0]    a_st;

  logic          b_rdy0, b_rdy1, b_we, b_ce, b_gnt, b_busy;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic [1:0]    b_st;

  int n_tests = 0;
  int n_fail  = 0;

  fb_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(64)) dut_a (
    .clk_in(clk_in), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_lock(req0_lock), .req1_lock(req1_lock),
    .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_ready(a_rdy0), .req1_ready(a_rdy1),
    .ram_address(a_addr), .ram_data_out(a_data),
    .ram_write_enable(a_we), .ram_clk_enable(a_ce),
    .grant_id(a_gnt), .busy(a_busy), .o_dbg_state(a_st)
  );

  fb_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(4)) dut_b (
    .clk_in(clk_in), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_lock(req0_lock), .req1_lock(req1_lock),
    .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_ready(b_rdy0), .req1_ready(b_rdy1),
    .ram_address(b_addr), .ram_data_out(b_data),
    .ram_write_enable(b_we), .ram_clk_enable(b_ce),
    .grant_id(b_gnt), .busy(b_busy), .o_dbg_state(b_st)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set0(input logic v, input logic l, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req0_valid = v; req0_lock = l; req0_addr = a; req0_data = d;
    #1;
  endtask

  task automatic set1(input logic v, input logic l, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req1_valid = v; req1_lock = l; req1_addr = a; req1_data = d;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b0, 1'b0, '0, '0);
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic       g;
    logic [3:0] exp_g;
    exp_g = RR ? 4'b1010 : 4'b0000;

    // Reset state, with both requesters valid so nothing may be accepted.
    reset = 1'b1;
    set0(1'b1, 1'b1, 11'h7AA, 16'h1111);
    set1(1'b1, 1'b1, 11'h755, 16'h2222);
    tick();
    tick();
    chk("rst_rdy0", a_rdy0, 1'b0);
    chk("rst_rdy1", a_rdy1, 1'b0);
    chk("rst_we", a_we, 1'b0);
    chk("rst_ce", a_ce, 1'b0);
    chk("rst_addr", a_addr, 11'h000);
    chk("rst_data", a_data, 16'h0000);
    chk("rst_gnt", a_gnt, 1'b1);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_state", a_st, 2'd0);
    do_reset();

    // Single unlocked beat from req0.
    set0(1'b1, 1'b0, 11'h010, 16'hBEEF);
    chk("single_rdy0", a_rdy0, 1'b1);
    chk("single_rdy1", a_rdy1, 1'b0);
    tick();
    set0(1'b0, 1'b0, 11'h000, 16'h0000);
    chk("single_we", a_we, 1'b1);
    chk("single_ce", a_ce, 1'b1);
    chk("single_addr", a_addr, 11'h010);
    chk("single_data", a_data, 16'hBEEF);
    chk("single_gnt", a_gnt, 1'b0);
    chk("single_busy", a_busy, 1'b1);
    chk("single_state", a_st, 2'd0);
    tick();
    chk("single_we_off", a_we, 1'b0);
    chk("single_addr_hold", a_addr, 11'h010);
    chk("single_data_hold", a_data, 16'hBEEF);
    chk("single_busy_off", a_busy, 1'b0);

    // Four-cycle tie with lock low.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set0(1'b1, 1'b0, 11'(11'h100 + i), 16'(16'hA000 + i));
      set1(1'b1, 1'b0, 11'(11'h200 + i), 16'(16'hB000 + i));
      g = exp_g[i];
      chk("tie_rdy0", a_rdy0, !g);
      chk("tie_rdy1", a_rdy1, g);
      tick();
      chk("tie_we", a_we, 1'b1);
      chk("tie_gnt", a_gnt, g);
      chk("tie_addr", a_addr, g ? 11'(11'h200 + i) : 11'(11'h100 + i));
      chk("tie_data", a_data, g ? 16'(16'hB000 + i) : 16'(16'hA000 + i));
    end
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b0, 1'b0, '0, '0);
    tick();
    chk("tie_we_off", a_we, 1'b0);

    // Five-beat locked burst from req0 with req1 waiting; lock drops on the last beat.
    do_reset();
    set1(1'b1, 1'b0, 11'h300, 16'hC0DE);
    for (int i = 0; i < 5; i++) begin
      set0(1'b1, (i < 4), 11'(11'h040 + i), 16'(16'hD000 + i));
      chk("burst_rdy0", a_rdy0, 1'b1);
      chk("burst_rdy1", a_rdy1, 1'b0);
      tick();
      chk("burst_we", a_we, 1'b1);
      chk("burst_addr", a_addr, 11'(11'h040 + i));
      chk("burst_gnt", a_gnt, 1'b0);
      chk("burst_state", a_st, (i < 4) ? 2'd1 : 2'd0);
    end
    set0(1'b0, 1'b0, '0, '0);
    chk("after_rdy1", a_rdy1, 1'b1);
    tick();
    chk("after_gnt", a_gnt, 1'b1);
    chk("after_addr", a_addr, 11'h300);
    chk("after_data", a_data, 16'hC0DE);

    // Owned with req0 idle but still locked: no strobes, ready held high.
    do_reset();
    set0(1'b1, 1'b1, 11'h020, 16'h0020);
    tick();
    chk("own_enter_state", a_st, 2'd1);
    set0(1'b0, 1'b1, 11'h021, 16'h0021);
    set1(1'b1, 1'b0, 11'h321, 16'h0321);
    for (int i = 0; i < 3; i++) begin
      chk("own_rdy0", a_rdy0, 1'b1);
      chk("own_rdy1", a_rdy1, 1'b0);
      tick();
      chk("own_we", a_we, 1'b0);
      chk("own_busy", a_busy, 1'b1);
      chk("own_state", a_st, 2'd1);
    end
    set0(1'b0, 1'b0, 11'h021, 16'h0021);
    tick();
    chk("own_release", a_st, 2'd0);

    // Burst limit of 4 on dut_b, then the IDLE tie.
    do_reset();
    set1(1'b1, 1'b0, 11'h3FF, 16'h0FFF);
    for (int i = 0; i < 4; i++) begin
      set0(1'b1, 1'b1, 11'(11'h050 + i), 16'(16'hE000 + i));
      chk("max_rdy0", b_rdy0, 1'b1);
      chk("max_rdy1", b_rdy1, 1'b0);
      tick();
      chk("max_we", b_we, 1'b1);
      chk("max_addr", b_addr, 11'(11'h050 + i));
      chk("max_state", b_st, (i < 3) ? 2'd1 : 2'd0);
    end
    set0(1'b1, 1'b1, 11'h060, 16'hE100);
    chk("max_idle_rdy1", b_rdy1, RR);
    chk("max_idle_rdy0", b_rdy0, !RR);
    tick();
    chk("max_idle_gnt", b_gnt, RR);
    chk("max_idle_addr", b_addr, RR ? 11'h3FF : 11'h060);

    // Reset lands on the third beat of a locked burst.
    do_reset();
    set1(1'b0, 1'b0, 11'h3AA, 16'h03AA);
    for (int i = 0; i < 2; i++) begin
      set0(1'b1, 1'b1, 11'(11'h070 + i), 16'(16'hF000 + i));
      tick();
    end
    chk("abort_pre_state", a_st, 2'd1);
    reset = 1'b1;
    set0(1'b1, 1'b1, 11'h072, 16'hF002);
    chk("abort_rdy0", a_rdy0, 1'b0);
    tick();
    chk("abort_we", a_we, 1'b0);
    chk("abort_state", a_st, 2'd0);
    chk("abort_gnt", a_gnt, 1'b1);
    chk("abort_addr", a_addr, 11'h000);
    reset = 1'b0;
    set0(1'b1, 1'b0, 11'h080, 16'h0080);
    set1(1'b1, 1'b0, 11'h380, 16'h0380);
    chk("abort_tie_rdy0", a_rdy0, 1'b1);
    chk("abort_tie_rdy1", a_rdy1, 1'b0);
    tick();
    chk("abort_tie_gnt", a_gnt, 1'b0);
    chk("abort_tie_addr", a_addr, 11'h080);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
